// File: rtl/reg_scoreboard_dec.sv
// Purpose : register-file write-enable decoder plus per-register busy scoreboard with RAW/WAW hazard flags.
// Latency : wb_en/busy/err_wb_idle registered (1 cycle); rs1_busy/rs2_busy/issue_ready combinational (0 cycles).
// Backpressure: issue_ready drops while any source or the destination is still in flight; writeback is never stalled.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   issue_valid/_rd/_has_rd, rs1_addr, rs2_addr   issue-stage request and its operands
//   issue_ready           issue accepted this cycle when issue_valid && issue_ready
//   rs1_busy, rs2_busy    source operand still waiting on an in-flight result
//   wb_valid, wb_rd       writeback-stage commit
//   wb_en                 one-hot register-file write enable, one cycle after wb_valid
//   busy                  scoreboard state, one bit per register
//   err_wb_idle           sticky: a writeback hit a register that was not in flight
//
// NREG must equal 2**ADDR_W so every address decodes to exactly one register.

module reg_scoreboard_dec #(
    parameter int ADDR_W         = 5,
    parameter int NREG           = 32,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_has_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              issue_ready,
    output logic              rs1_busy,
    output logic              rs2_busy,

    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic [NREG-1:0]   wb_en,
    output logic [NREG-1:0]   busy,
    output logic              err_wb_idle
);

    localparam bit ZERO_HW = (ZERO_HARDWIRED != 0);

    // Decoded clear (writeback) and set (accepted issue) vectors.
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;

    // Hazard terms.
    logic rd_busy;
    logic issue_fire;
    logic wb_hits_idle;

    // Register 0 is excluded from every decode when it is hardwired to zero.
    logic rs1_is_zero;
    logic rs2_is_zero;
    logic rd_is_zero;

    assign rs1_is_zero = ZERO_HW && (rs1_addr == '0);
    assign rs2_is_zero = ZERO_HW && (rs2_addr == '0);
    assign rd_is_zero  = ZERO_HW && (issue_rd == '0);

    // Writeback clear vector: one-hot of wb_rd, bit 0 suppressed when hardwired.
    always_comb begin
        clr_vec = '0;
        if (wb_valid) begin
            clr_vec[wb_rd] = 1'b1;
        end
        if (ZERO_HW) begin
            clr_vec[0] = 1'b0;
        end
    end

    // A register being written back this cycle no longer blocks readers or a
    // new writer: the bypass lets the dependent instruction issue in the same
    // cycle the producer retires.
    always_comb begin
        rs1_busy = busy[rs1_addr] && !clr_vec[rs1_addr] && !rs1_is_zero;
        rs2_busy = busy[rs2_addr] && !clr_vec[rs2_addr] && !rs2_is_zero;
        rd_busy  = issue_has_rd && busy[issue_rd] && !clr_vec[issue_rd] && !rd_is_zero;
    end

    // Ready never looks at issue_valid so the issue stage can use it to decide
    // whether to present an instruction at all.
    assign issue_ready = !rs1_busy && !rs2_busy && !rd_busy;
    assign issue_fire  = issue_valid && issue_ready && issue_has_rd;

    always_comb begin
        set_vec = '0;
        if (issue_fire) begin
            set_vec[issue_rd] = 1'b1;
        end
        if (ZERO_HW) begin
            set_vec[0] = 1'b0;
        end
    end

    // A writeback to a register that is not in flight indicates a pipeline
    // bookkeeping bug upstream; clr_vec gating keeps hardwired r0 out of it.
    assign wb_hits_idle = wb_valid && !busy[wb_rd] && clr_vec[wb_rd];

    // Set is OR'ed after the clear so an issue to the register being written
    // back keeps it busy, now owned by the newly issued instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            wb_en       <= '0;
            err_wb_idle <= 1'b0;
        end else begin
            busy        <= (busy & ~clr_vec) | set_vec;
            wb_en       <= clr_vec;
            err_wb_idle <= err_wb_idle | wb_hits_idle;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard_dec.sv
// Purpose : directed self-checking bench for reg_scoreboard_dec, with r0 hardwired (z1) and not (z0).
// Latency : combinational flags checked 1 time unit after inputs settle; registered outputs 1 unit after the edge.
// Backpressure: none; issue_ready is only observed.

module tb_reg_scoreboard_dec;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_has_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        wb_valid;
    logic [4:0]  wb_rd;

    logic        z1_ready, z1_rs1_busy, z1_rs2_busy, z1_err;
    logic [31:0] z1_wb_en, z1_busy;
    logic        z0_ready, z0_rs1_busy, z0_rs2_busy, z0_err;
    logic [31:0] z0_wb_en, z0_busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_scoreboard_dec #(.ADDR_W(5), .NREG(32), .ZERO_HARDWIRED(1)) u_z1 (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_has_rd(issue_has_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .issue_ready(z1_ready), .rs1_busy(z1_rs1_busy), .rs2_busy(z1_rs2_busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_en(z1_wb_en), .busy(z1_busy), .err_wb_idle(z1_err)
    );

    reg_scoreboard_dec #(.ADDR_W(5), .NREG(32), .ZERO_HARDWIRED(0)) u_z0 (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_has_rd(issue_has_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .issue_ready(z0_ready), .rs1_busy(z0_rs1_busy), .rs2_busy(z0_rs2_busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_en(z0_wb_en), .busy(z0_busy), .err_wb_idle(z0_err)
    );

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        issue_rd     = 5'd0;
        issue_has_rd = 1'b0;
        rs1_addr     = 5'd0;
        rs2_addr     = 5'd0;
        wb_valid     = 1'b0;
        wb_rd        = 5'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (z1_busy !== 32'h0) begin n_bad++; $display("FAIL reset_busy_z1 got=%h exp=%h", z1_busy, 32'h0); end
        n_cmp++; if (z1_wb_en !== 32'h0) begin n_bad++; $display("FAIL reset_wb_en_z1 got=%h exp=%h", z1_wb_en, 32'h0); end
        n_cmp++; if (z1_err !== 1'b0) begin n_bad++; $display("FAIL reset_err_z1 got=%b exp=0", z1_err); end
        n_cmp++; if (z0_busy !== 32'h0) begin n_bad++; $display("FAIL reset_busy_z0 got=%h exp=%h", z0_busy, 32'h0); end
        // Idle ready for several operand combinations, including r0.
        for (int k = 0; k < 4; k++) begin
            rs1_addr     = 5'(k * 9);
            rs2_addr     = 5'(31 - k * 7);
            issue_rd     = 5'(k * 10 + 1);
            issue_has_rd = 1'b1;
            settle();
            n_cmp++; if (z1_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_z1 k=%0d got=%b exp=1", k, z1_ready); end
            n_cmp++; if (z0_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_z0 k=%0d got=%b exp=1", k, z0_ready); end
        end
        idle_inputs();
    endtask

    task automatic test_raw_bypass();
        do_reset();
        // cycle 0: issue rd=5
        issue_valid = 1'b1; issue_rd = 5'd5; issue_has_rd = 1'b1;
        settle();
        n_cmp++; if (z1_ready !== 1'b1) begin n_bad++; $display("FAIL raw_c0_ready got=%b exp=1", z1_ready); end
        tick();
        // cycle 1: read r5
        idle_inputs(); rs1_addr = 5'd5;
        settle();
        n_cmp++; if (z1_busy !== 32'h0000_0020) begin n_bad++; $display("FAIL raw_c1_busy got=%h exp=%h", z1_busy, 32'h20); end
        n_cmp++; if (z1_rs1_busy !== 1'b1) begin n_bad++; $display("FAIL raw_c1_rs1_busy got=%b exp=1", z1_rs1_busy); end
        n_cmp++; if (z1_ready !== 1'b0) begin n_bad++; $display("FAIL raw_c1_ready got=%b exp=0", z1_ready); end
        tick();
        // cycle 2: rs2 hazard, then WAW hazard with and without a destination
        idle_inputs(); rs2_addr = 5'd5;
        settle();
        n_cmp++; if (z1_rs2_busy !== 1'b1) begin n_bad++; $display("FAIL raw_c2_rs2_busy got=%b exp=1", z1_rs2_busy); end
        rs2_addr = 5'd0; issue_rd = 5'd5; issue_has_rd = 1'b1;
        settle();
        n_cmp++; if (z1_ready !== 1'b0) begin n_bad++; $display("FAIL waw_ready got=%b exp=0", z1_ready); end
        issue_has_rd = 1'b0;
        settle();
        n_cmp++; if (z1_ready !== 1'b1) begin n_bad++; $display("FAIL waw_no_rd_ready got=%b exp=1", z1_ready); end
        tick();
        // cycle 3: writeback r5 bypasses the hazard
        idle_inputs(); rs1_addr = 5'd5; wb_valid = 1'b1; wb_rd = 5'd5;
        settle();
        n_cmp++; if (z1_rs1_busy !== 1'b0) begin n_bad++; $display("FAIL raw_c3_rs1_busy got=%b exp=0", z1_rs1_busy); end
        n_cmp++; if (z1_ready !== 1'b1) begin n_bad++; $display("FAIL raw_c3_ready got=%b exp=1", z1_ready); end
        n_cmp++; if (z1_wb_en !== 32'h0) begin n_bad++; $display("FAIL raw_c3_wb_en got=%h exp=%h", z1_wb_en, 32'h0); end
        tick();
        // cycle 4
        idle_inputs();
        settle();
        n_cmp++; if (z1_busy !== 32'h0) begin n_bad++; $display("FAIL raw_c4_busy got=%h exp=%h", z1_busy, 32'h0); end
        n_cmp++; if (z1_wb_en !== 32'h0000_0020) begin n_bad++; $display("FAIL raw_c4_wb_en got=%h exp=%h", z1_wb_en, 32'h20); end
        n_cmp++; if (z1_err !== 1'b0) begin n_bad++; $display("FAIL raw_c4_err got=%b exp=0", z1_err); end
        tick();
        n_cmp++; if (z1_wb_en !== 32'h0) begin n_bad++; $display("FAIL raw_c5_wb_en got=%h exp=%h", z1_wb_en, 32'h0); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_has_rd = 1'b1;
        tick();
        n_cmp++; if (z1_busy !== 32'h0000_0080) begin n_bad++; $display("FAIL same_setup_busy got=%h exp=%h", z1_busy, 32'h80); end
        // Writeback and re-issue of r7 together.
        wb_valid = 1'b1; wb_rd = 5'd7;
        settle();
        n_cmp++; if (z1_ready !== 1'b1) begin n_bad++; $display("FAIL same_ready got=%b exp=1", z1_ready); end
        tick();
        idle_inputs();
        settle();
        n_cmp++; if (z1_busy !== 32'h0000_0080) begin n_bad++; $display("FAIL same_busy got=%h exp=%h", z1_busy, 32'h80); end
        n_cmp++; if (z1_wb_en !== 32'h0000_0080) begin n_bad++; $display("FAIL same_wb_en got=%h exp=%h", z1_wb_en, 32'h80); end
        n_cmp++; if (z1_err !== 1'b0) begin n_bad++; $display("FAIL same_err got=%b exp=0", z1_err); end
        wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        idle_inputs();
        n_cmp++; if (z1_busy !== 32'h0) begin n_bad++; $display("FAIL same_drain_busy got=%h exp=%h", z1_busy, 32'h0); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd0; issue_has_rd = 1'b1;
        tick();
        idle_inputs();
        n_cmp++; if (z1_busy !== 32'h0) begin n_bad++; $display("FAIL zero_busy_z1 got=%h exp=%h", z1_busy, 32'h0); end
        n_cmp++; if (z0_busy !== 32'h1) begin n_bad++; $display("FAIL zero_busy_z0 got=%h exp=%h", z0_busy, 32'h1); end
        rs1_addr = 5'd0;
        settle();
        n_cmp++; if (z1_rs1_busy !== 1'b0) begin n_bad++; $display("FAIL zero_rs1_z1 got=%b exp=0", z1_rs1_busy); end
        n_cmp++; if (z0_rs1_busy !== 1'b1) begin n_bad++; $display("FAIL zero_rs1_z0 got=%b exp=1", z0_rs1_busy); end
        idle_inputs(); wb_valid = 1'b1; wb_rd = 5'd0;
        tick();
        idle_inputs();
        n_cmp++; if (z1_wb_en !== 32'h0) begin n_bad++; $display("FAIL zero_wb_en_z1 got=%h exp=%h", z1_wb_en, 32'h0); end
        n_cmp++; if (z1_err !== 1'b0) begin n_bad++; $display("FAIL zero_err_z1 got=%b exp=0", z1_err); end
        n_cmp++; if (z0_wb_en !== 32'h1) begin n_bad++; $display("FAIL zero_wb_en_z0 got=%h exp=%h", z0_wb_en, 32'h1); end
        n_cmp++; if (z0_busy !== 32'h0) begin n_bad++; $display("FAIL zero_clear_z0 got=%h exp=%h", z0_busy, 32'h0); end
        n_cmp++; if (z0_err !== 1'b0) begin n_bad++; $display("FAIL zero_err_z0 got=%b exp=0", z0_err); end
    endtask

    task automatic test_err_and_reset();
        do_reset();
        wb_valid = 1'b1; wb_rd = 5'd9;
        tick();
        idle_inputs();
        n_cmp++; if (z1_err !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b exp=1", z1_err); end
        n_cmp++; if (z1_wb_en !== 32'h0000_0200) begin n_bad++; $display("FAIL err_wb_en got=%h exp=%h", z1_wb_en, 32'h200); end
        issue_valid = 1'b1; issue_rd = 5'd8; issue_has_rd = 1'b1;
        tick();
        issue_rd = 5'd9;
        tick();
        idle_inputs();
        n_cmp++; if (z1_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b exp=1", z1_err); end
        n_cmp++; if (z1_busy !== 32'h0000_0300) begin n_bad++; $display("FAIL err_busy got=%h exp=%h", z1_busy, 32'h300); end
        // Reset wins over a concurrent writeback and issue.
        rst = 1'b1; wb_valid = 1'b1; wb_rd = 5'd8;
        issue_valid = 1'b1; issue_rd = 5'd10; issue_has_rd = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        n_cmp++; if (z1_busy !== 32'h0) begin n_bad++; $display("FAIL rst_busy got=%h exp=%h", z1_busy, 32'h0); end
        n_cmp++; if (z1_wb_en !== 32'h0) begin n_bad++; $display("FAIL rst_wb_en got=%h exp=%h", z1_wb_en, 32'h0); end
        n_cmp++; if (z1_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", z1_err); end
        // In-flight r8 was discarded, so its late writeback is an error.
        wb_valid = 1'b1; wb_rd = 5'd8;
        tick();
        idle_inputs();
        n_cmp++; if (z1_err !== 1'b1) begin n_bad++; $display("FAIL post_rst_err got=%b exp=1", z1_err); end
    endtask

    task automatic test_walk();
        logic [31:0] exp0;
        logic [31:0] exp1;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(i);
            tick();
            exp0 = 32'h1 << i;
            exp1 = (i == 0) ? 32'h0 : exp0;
            n_cmp++; if (z0_wb_en !== exp0) begin n_bad++; $display("FAIL walk_z0 rd=%0d got=%h exp=%h", i, z0_wb_en, exp0); end
            n_cmp++; if ($countones(z0_wb_en) != 1) begin n_bad++; $display("FAIL walk_onehot rd=%0d got=%0d exp=1", i, $countones(z0_wb_en)); end
            n_cmp++; if (z1_wb_en !== exp1) begin n_bad++; $display("FAIL walk_z1 rd=%0d got=%h exp=%h", i, z1_wb_en, exp1); end
        end
        idle_inputs();
        tick();
        n_cmp++; if (z0_wb_en !== 32'h0) begin n_bad++; $display("FAIL walk_idle got=%h exp=%h", z0_wb_en, 32'h0); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_raw_bypass();
        test_same_cycle();
        test_zero_reg();
        test_err_and_reset();
        test_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
